// File: rtl/wisc_pkg.sv
// Shared widths, encodings and the fetch-queue entry type for the 16-bit
// pipelined processor.
package wisc_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]         OPC_HALT  = 5'b00000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pcPlus2;
  } queueEntry_t;

  function automatic logic isHalt(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 5] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory req/ack, downstream redirect and the
// valid/ready hand-off to decode. master = fetch side, slave = environment.
interface fetch_stage_if;
  import wisc_pkg::*;

  logic               imemReq;
  logic [PC_W-1:0]    imemAddr;
  logic               imemAck;
  logic [INSTR_W-1:0] imemData;
  logic               redirect;
  logic [PC_W-1:0]    redirectPc;
  logic               decReady;
  logic               instrValid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pcPlus2;
  logic               halted;
  logic               err;

  modport master (
    output imemReq, imemAddr, instrValid, instr, pcPlus2, halted, err,
    input  imemAck, imemData, redirect, redirectPc, decReady
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instr, pcPlus2, halted, err,
    output imemAck, imemData, redirect, redirectPc, decReady
  );

endinterface

// File: rtl/fetch_stage_instr_queue.sv
// DEPTH-entry circular FIFO of {instr, pcPlus2}; flush empties it in one
// cycle and leaves the stale head entry visible.
module instr_queue
  import wisc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  queueEntry_t   pushEntry,
  output logic [CW-1:0] count,
  output queueEntry_t   head
);

  queueEntry_t     mem [DEPTH];
  logic [AW-1:0]   headPtr;
  logic [AW-1:0]   tailPtr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{instr: NOP_INSTR, pcPlus2: '0};
      end
    end else if (flush) begin
      tailPtr <= headPtr;
      count   <= '0;
    end else begin
      if (push) begin
        mem[tailPtr] <= pushEntry;
        tailPtr      <= tailPtr + AW'(1);
      end
      if (pop) begin
        headPtr <= headPtr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[headPtr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches and queues
// results for decode. Optional HALT detection under FETCH_HALT_DETECT_EN.
module fetch_stage
  import wisc_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0] fetchPc;
  logic [PC_W-1:0] reqAddr;
  logic            outstanding;
  logic            drop;
  logic            err;
  logic            halted;
  logic [CW-1:0]   count;
  queueEntry_t     head;
  queueEntry_t     pushEntry;

  logic            accept;
  logic            pop;
  logic            issue;
  logic            outAfter;
  logic            dropAfter;
  logic            haltedAfter;
  logic [PC_W-1:0] pcPlus2Next;
  logic [PC_W-1:0] fetchPcAfter;
  logic [CW-1:0]   countAfter;

  // Everything is evaluated on the post-cycle view so the next request can
  // go out back-to-back with an ack, giving one fetch per cycle.
  always_comb begin
    accept       = bus.imemAck && outstanding && !drop && !bus.redirect;
    pop          = (count != '0) && bus.decReady && !bus.redirect;
    pcPlus2Next  = fetchPc + 16'd2;
    pushEntry    = '{instr: bus.imemData, pcPlus2: pcPlus2Next};
    fetchPcAfter = bus.redirect ? bus.redirectPc : (accept ? pcPlus2Next : fetchPc);
    outAfter     = outstanding && !bus.imemAck;
    dropAfter    = bus.redirect ? outAfter : (drop && outAfter);
    countAfter   = bus.redirect ? '0 : (count + CW'(accept) - CW'(pop));
`ifdef FETCH_HALT_DETECT_EN
    haltedAfter  = !bus.redirect && (halted || (accept && isHalt(bus.imemData)));
`else
    haltedAfter  = 1'b0;
`endif
    issue        = !outAfter && (countAfter < DEPTH_C) && !haltedAfter;
  end

  // A request stays outstanding, at its latched address, until its ack,
  // even when a redirect has already marked its response for dropping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc     <= RESET_PC;
      reqAddr     <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      err         <= 1'b0;
    end else begin
      fetchPc     <= fetchPcAfter;
      drop        <= dropAfter;
      outstanding <= outAfter || issue;
      if (issue) begin
        reqAddr <= fetchPcAfter;
      end
      if (bus.imemAck && !outstanding) begin
        err <= 1'b1;
      end
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else begin
      halted <= haltedAfter;
    end
  end
`else
  assign halted = 1'b0;
`endif

  instr_queue #(.DEPTH(DEPTH)) queue (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (pop),
    .flush     (bus.redirect),
    .pushEntry (pushEntry),
    .count     (count),
    .head      (head)
  );

  assign bus.imemReq    = outstanding;
  assign bus.imemAddr   = reqAddr;
  assign bus.instrValid = (count != '0);
  assign bus.instr      = head.instr;
  assign bus.pcPlus2    = head.pcPlus2;
  assign bus.halted     = halted;
  assign bus.err        = err;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined processor, directly upstream of decode. Owns the program counter and issues word fetches to instruction memory over a req/ack handshake that tolerates variable latency. Buffers returned instructions in a small queue and presents them to decode with a valid/ready handshake. Accepts branch and jump redirects from downstream, flushing wrong-path state.

## Interface
- DEPTH, 2 — instruction queue entries; power of two, at least 2.
- RESET_PC, 16'h0000 — fetch address after reset.
- clk  in  1  — sole clock, rising edge.
- rst  in  1  — asynchronous, active-low reset.
- imemReq  out  1  — fetch request; held high until the matching imemAck.
- imemAddr  out  16  — fetch address; stable while imemReq is high.
- imemAck  in  1  — one-cycle response strobe; legal in any cycle imemReq is high, including the first.
- imemData  in  16  — instruction word; valid with imemAck.
- redirect  in  1  — taken branch or jump from downstream.
- redirectPc  in  16  — new fetch address; valid with redirect.
- decReady  in  1  — decode accepts the head instruction this cycle.
- instrValid  out  1  — queue non-empty.
- instr  out  16  — head instruction.
- pcPlus2  out  16  — head instruction's address + 2.
- halted  out  1  — fetch stopped on HALT (see Configuration).
- err  out  1  — sticky protocol error.

## Operation
- State: fetchPc, outstanding flag, drop flag, halted, err, and a queue of {instr, pcPlus2} entries with head/tail pointers and a count.
- Issue: imemReq next cycle is 1 when all of the following hold next cycle: no outstanding request, count + outstanding < DEPTH, and not halted. imemAddr = fetchPc.
- Accept: imemAck with outstanding request and drop=0 pushes {imemData, fetchPc+2}. fetchPc <= fetchPc+2. Outstanding clears.
- Drop: imemAck with drop=1 discards the data, clears drop and outstanding, and leaves fetchPc unchanged.
- Pop: instrValid && decReady advances head.
- Redirect (highest priority):
  - fetchPc <= redirectPc; queue cleared (count 0); halted cleared.
  - If a request is outstanding and not acked this cycle, drop <= 1. The in-flight request completes at its original address and its response is discarded.
  - redirect coinciding with imemAck discards that response; drop is not set.
  - A coincident pop or push is overridden; the queue is empty the next cycle.
- Arithmetic: all PC sums are 16-bit modulo; 16'hFFFE + 2 wraps to 16'h0000 with no flag.
- err: set when imemAck arrives with no outstanding request. Cleared only by reset. The stray data is ignored.
- Full queue: the issue rule guarantees there is never a push into a full queue.
- Empty queue: instrValid=0; instr/pcPlus2 show the stale head entry.

## Timing
- Reset values: imemReq 0, imemAddr RESET_PC, instrValid 0, instr 16'h0800 (NOP; all entries reset to NOP), pcPlus2 16'h0000, halted 0, err 0; drop, outstanding and count all 0.
- First imemReq is asserted in the first cycle after rst deasserts.
- Latency: imemAck in cycle N gives instrValid in cycle N+1; there is no bypass.
- With zero-wait memory (ack in the same cycle as req) and decReady held high, sustained throughput is one instruction per cycle.
- Redirect in cycle N:
  - instrValid=0 in N+1.
  - If no request is outstanding after N, imemReq is asserted with redirectPc in N+1.
  - Otherwise the new request follows one cycle after the dropped ack.
- Reset mid-operation clears everything asynchronously. A later ack for a pre-reset request sets err.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - An accepted instruction with instr[15:11]==5'b00000 is enqueued normally and sets halted.
  - No further requests are issued.
  - halted clears only on redirect or reset.
- Undefined: halted is tied 0 and fetch continues past HALT; decode's halt handling alone stops the machine.

## Structure
- Shared package wisc_pkg holds INSTR_W=16, PC_W=16, NOP_INSTR=16'h0800, OPC_HALT=5'b00000.
- Sub-module instr_queue: DEPTH-entry circular FIFO with push, pop, flush, count, and head outputs.
- The PC, handshake and halt logic stay in fetch_stage.

## Test plan
- Reset, then zero-wait memory returning 16'h0800 at every address, with decReady=1 → imemAddr sequence 0000, 0002, 0004…; instrValid high every cycle from the 2nd; pcPlus2 = 0002, 0004….
- 3-cycle memory latency with decReady=0 → two instructions enqueued, then imemReq stays 0. Raise decReady → one pop, then one new request.
- Redirect to 16'h0100 while a request to 16'h0006 awaits ack → the 0006 ack is discarded, next imemAddr=0100, first pcPlus2 presented = 0102.
- Redirect in the same cycle as an ack → data discarded, drop not set, next request at redirectPc.
- With FETCH_HALT_DETECT_EN, memory returns 16'h0000 at 0004 → HALT enqueued with pcPlus2=0006, halted=1, no further imemReq. Redirect to 0020 → halted=0 and fetch resumes at 0020.
- imemAck pulsed with imemReq=0 → err=1, held until rst is low; queue unchanged.
